// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register index and hazard controller state.
package cpu_types_pkg;

    localparam int REG_W = 5;

    typedef logic [REG_W-1:0] regbits_t;

    typedef enum logic [1:0] {
        RUN,
        MEMWAIT,
        HALTED
    } hz_state_t;

endpackage

// File: rtl/lu_detect.sv
// Load-use compare between the EX load and the decode sources.
import cpu_types_pkg::*;

module lu_detect (
    input  logic     ex_memread,
    input  regbits_t ex_rd,
    input  regbits_t id_rs,
    input  regbits_t id_rt,
    input  logic     id_use_rs,
    input  logic     id_use_rt,
    output logic     hit
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit = id_use_rs && (id_rs == ex_rd);
    assign rt_hit = id_use_rt && (id_rt == ex_rd);

    // r0 is hardwired, so a load into it never creates a dependency
    assign hit = ex_memread && (ex_rd != '0) && (rs_hit || rt_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: latch enables/flushes, PC enable,
// memory-wait FSM, halt and stall counting.
import cpu_types_pkg::*;

module hazard_ctrl #(
    parameter int NSTAGES    = 5,
    parameter int MEM_IDX    = 3,
    parameter int BR_IDX     = 2,
    parameter int LU_BUBBLES = 1,
    parameter int WAIT_MAX   = 255,
    parameter int CNTW       = 16
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic               ihit,
    input  logic               dhit,
    input  logic               mem_req,
    input  regbits_t           id_rs,
    input  regbits_t           id_rt,
    input  logic               id_use_rs,
    input  logic               id_use_rt,
    input  regbits_t           ex_rd,
    input  logic               ex_memread,
    input  logic               br_taken,
    input  logic               jmp,
    input  logic               halt_wb,
    output logic               pc_en,
    output logic [NSTAGES-2:0] stage_en,
    output logic [NSTAGES-2:0] stage_flush,
    output logic               halted,
    output logic               mem_timeout,
    output logic [CNTW-1:0]    stall_cnt
);

    localparam int WW = $clog2(WAIT_MAX + 1);
    localparam logic [WW-1:0] WMAX = WW'(WAIT_MAX);
    localparam logic [1:0] LU_LOAD = 2'(LU_BUBBLES - 1);

    hz_state_t     state;
    hz_state_t     state_nxt;
    logic [1:0]    lu_cnt;
    logic [1:0]    lu_nxt;
    logic [WW-1:0] wait_cnt;
    logic [WW-1:0] wait_nxt;
    logic          lu_hit;

    lu_detect u_lu (
        .ex_memread (ex_memread),
        .ex_rd      (ex_rd),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_use_rs  (id_use_rs),
        .id_use_rt  (id_use_rt),
        .hit        (lu_hit)
    );

    always_comb begin
        stage_en    = '1;
        stage_flush = '0;
        pc_en       = 1'b1;
        state_nxt   = state;
        lu_nxt      = lu_cnt;
        wait_nxt    = wait_cnt;

        if (!nRST) begin
            stage_en    = '0;
            stage_flush = '1;
            pc_en       = 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_req && !dhit) begin
                        stage_en[MEM_IDX-1:0] = '0;
                        stage_flush[MEM_IDX]  = 1'b1;
                        pc_en                 = 1'b0;
                        state_nxt             = MEMWAIT;
                        wait_nxt              = WW'(1);
                    end else if (halt_wb) begin
                        state_nxt = HALTED;
                    end else if (br_taken) begin
                        stage_flush[BR_IDX-1:0] = '1;
                        lu_nxt                  = '0;
                    end else if (lu_hit || lu_cnt != '0) begin
                        pc_en          = 1'b0;
                        stage_en[0]    = 1'b0;
                        stage_flush[1] = 1'b1;
                        lu_nxt = (lu_cnt != '0) ? lu_cnt - 2'd1 : LU_LOAD;
                    end else if (jmp) begin
                        stage_flush[0] = 1'b1;
                    end else if (!ihit) begin
                        pc_en          = 1'b0;
                        stage_flush[0] = 1'b1;
                    end
                end
                MEMWAIT: begin
                    if (dhit || !mem_req) begin
                        state_nxt = RUN;
                        wait_nxt  = '0;
                    end else begin
                        stage_en[MEM_IDX-1:0] = '0;
                        stage_flush[MEM_IDX]  = 1'b1;
                        pc_en                 = 1'b0;
                        if (wait_cnt != WMAX) wait_nxt = wait_cnt + 1'b1;
                    end
                end
                HALTED: begin
                    stage_en    = '0;
                    stage_flush = '0;
                    pc_en       = 1'b0;
                end
                default: begin
                    state_nxt = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= RUN;
            lu_cnt      <= '0;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
            stall_cnt   <= '0;
        end else begin
            state    <= state_nxt;
            lu_cnt   <= lu_nxt;
            wait_cnt <= wait_nxt;
            if (wait_cnt == WMAX) mem_timeout <= 1'b1;
            if (!pc_en && state != HALTED && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign halted = (state == HALTED);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl (LU_BUBBLES=2, WAIT_MAX=3).
import cpu_types_pkg::*;

module tb_hazard_ctrl;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit, dhit, mem_req;
    logic [4:0]  id_rs, id_rt, ex_rd;
    logic        id_use_rs, id_use_rt, ex_memread;
    logic        br_taken, jmp, halt_wb;
    logic        pc_en, halted, mem_timeout;
    logic [3:0]  stage_en, stage_flush;
    logic [15:0] stall_cnt;

    typedef struct {
        string       tag;
        logic [3:0]  en;
        logic [3:0]  fl;
        logic        pc;
        logic        hl;
        logic        to;
        logic [15:0] sc;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    hazard_ctrl #(
        .NSTAGES(5), .MEM_IDX(3), .BR_IDX(2),
        .LU_BUBBLES(2), .WAIT_MAX(3), .CNTW(16)
    ) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .mem_req(mem_req), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .ex_rd(ex_rd), .ex_memread(ex_memread),
        .br_taken(br_taken), .jmp(jmp), .halt_wb(halt_wb),
        .pc_en(pc_en), .stage_en(stage_en),
        .stage_flush(stage_flush), .halted(halted),
        .mem_timeout(mem_timeout), .stall_cnt(stall_cnt)
    );

    always #5 CLK = ~CLK;

    // Monitor: outputs settle by the falling edge
    always @(negedge CLK) begin
        exp_t e;
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            n_cmp++;
            if ({stage_en, stage_flush, pc_en, halted, mem_timeout, stall_cnt}
                !== {e.en, e.fl, e.pc, e.hl, e.to, e.sc}) begin
                n_bad++;
                $display("FAIL %s: got en=%b fl=%b pc=%b hl=%b to=%b sc=%0d want en=%b fl=%b pc=%b hl=%b to=%b sc=%0d",
                         e.tag, stage_en, stage_flush, pc_en, halted,
                         mem_timeout, stall_cnt, e.en, e.fl, e.pc, e.hl,
                         e.to, e.sc);
            end
        end
    end

    task automatic step(input string tag, input logic [3:0] en,
                        input logic [3:0] fl, input logic pc,
                        input logic hl, input logic to, input int sc);
        exp_t e;
        e.tag = tag; e.en = en; e.fl = fl; e.pc = pc;
        e.hl = hl; e.to = to; e.sc = 16'(sc);
        sbq.push_back(e);
        @(posedge CLK); #1;
    endtask

    task automatic base(input string tag, input logic to, input int sc);
        step(tag, 4'b1111, 4'b0000, 1'b1, 1'b0, to, sc);
    endtask

    task automatic lu_stall(input string tag, input int sc);
        step(tag, 4'b1110, 4'b0010, 1'b0, 1'b0, 1'b0, sc);
    endtask

    task automatic idle();
        ihit = 1; dhit = 0; mem_req = 0;
        id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        ex_rd = 0; ex_memread = 0;
        br_taken = 0; jmp = 0; halt_wb = 0;
    endtask

    task automatic do_reset();
        nRST = 0;
        idle();
        repeat (3) step("reset", 4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0, 0);
        nRST = 1;
        base("post_reset", 1'b0, 0);
    endtask

    task automatic set_lu(input logic [4:0] r);
        ex_memread = 1; ex_rd = r; id_rs = r; id_use_rs = 1;
    endtask

    initial begin
        int g;
        nRST = 0;
        idle();
        @(posedge CLK); #1;

        // Load-use, two bubbles, r0 and use-flag negatives
        do_reset();
        set_lu(5'd8);   lu_stall("lu_rs_1", 0);
        idle();         lu_stall("lu_rs_2", 1);
        base("lu_done", 1'b0, 2);
        set_lu(5'd0);   base("lu_r0", 1'b0, 2);
        idle();
        ex_memread = 1; ex_rd = 5; id_rt = 5; id_use_rt = 1;
        lu_stall("lu_rt_1", 2);
        idle();         lu_stall("lu_rt_2", 3);
        base("lu_rt_done", 1'b0, 4);
        ex_memread = 1; ex_rd = 7; id_rs = 7; id_rt = 7;
        base("lu_nouse", 1'b0, 4);
        idle();
        ex_rd = 7; id_rs = 7; id_use_rs = 1;
        base("lu_noload", 1'b0, 4);

        // Memory miss, timeout, mem_req drop, miss beats halt
        do_reset();
        mem_req = 1;
        step("miss_1", 4'b1000, 4'b1000, 1'b0, 1'b0, 1'b0, 0);
        step("miss_2", 4'b1000, 4'b1000, 1'b0, 1'b0, 1'b0, 1);
        step("miss_3", 4'b1000, 4'b1000, 1'b0, 1'b0, 1'b0, 2);
        step("miss_4", 4'b1000, 4'b1000, 1'b0, 1'b0, 1'b0, 3);
        dhit = 1;       base("miss_dhit", 1'b1, 4);
        idle();         base("timeout_sticky", 1'b1, 4);
        mem_req = 1; br_taken = 1; jmp = 1;
        step("miss_again", 4'b1000, 4'b1000, 1'b0, 1'b0, 1'b1, 4);
        idle();         base("req_drop", 1'b1, 5);
        mem_req = 1; halt_wb = 1;
        step("miss_vs_halt", 4'b1000, 4'b1000, 1'b0, 1'b0, 1'b1, 5);
        halt_wb = 0; dhit = 1;
        base("miss_end", 1'b1, 6);
        idle();         base("no_halt", 1'b1, 6);
        mem_req = 1; dhit = 1;
        base("req_hit", 1'b1, 6);

        // Branch, jump, fetch miss, branch clears bubbles
        do_reset();
        set_lu(5'd8); br_taken = 1;
        step("br_vs_lu", 4'b1111, 4'b0011, 1'b1, 1'b0, 1'b0, 0);
        idle();         base("br_nostall", 1'b0, 0);
        jmp = 1; ihit = 0;
        step("jmp_imiss", 4'b1111, 4'b0001, 1'b1, 1'b0, 1'b0, 0);
        jmp = 0;
        step("imiss", 4'b1111, 4'b0001, 1'b0, 1'b0, 1'b0, 0);
        idle();         base("imiss_done", 1'b0, 1);
        set_lu(5'd9); jmp = 1;
        lu_stall("lu_vs_jmp", 1);
        idle();         lu_stall("lu_vs_jmp_2", 2);
        base("lu_jmp_done", 1'b0, 3);
        set_lu(5'd9);   lu_stall("lu_then_br", 3);
        idle(); br_taken = 1;
        step("br_clears_lu", 4'b1111, 4'b0011, 1'b1, 1'b0, 1'b0, 4);
        idle();         base("lu_cleared", 1'b0, 4);

        // Halt is terminal until reset
        do_reset();
        ihit = 0;
        step("pre_halt", 4'b1111, 4'b0001, 1'b0, 1'b0, 1'b0, 0);
        ihit = 1; halt_wb = 1;
        base("halt_wb", 1'b0, 1);
        idle();
        step("halted_1", 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1);
        br_taken = 1; mem_req = 1; ihit = 0;
        step("halted_br", 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1);
        idle();
        step("halted_2", 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1);
        do_reset();

        g = 0;
        while (sbq.size() != 0 && g < 10) begin
            @(posedge CLK);
            g++;
        end
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, want 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
